// File: rtl/serial_mag_compare.sv
// serial_mag_compare: byte-serial unsigned magnitude comparator.
// Operands A and B arrive one byte pair per handshake, most-significant byte
// first. A running equal/greater pair is kept between bytes and the final
// eq/gt flags are held for the consumer until the next accepted start.
// Optional feature macro: SMC_EARLY_DONE_EN. When it is defined, done is
// reported as soon as the result is decided. The remaining byte pairs are
// still accepted in DRAIN, and their data is ignored.
module serial_mag_compare #(
    parameter int WORDS = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [7:0] a_byte_i,
    input  logic [7:0] b_byte_i,
    input  logic       byte_valid_i,
    output logic       byte_ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       eq_o,
    output logic       gt_o
);

    localparam int            CW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2
`ifdef SMC_EARLY_DONE_EN
        , DRAIN = 2'd3
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          run_eq_q, run_eq_d;
    logic          run_gt_q, run_gt_d;
    logic          eq_q, eq_d;
    logic          gt_q, gt_d;
    logic          done_q, done_d;
    logic          pair_eq, pair_gt;

    // Control state, counter and result flags; reset discards any partial result
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    // Running compare state; it is always re-initialised by an accepted start
    always_ff @(posedge clk_i) begin
        run_eq_q <= run_eq_d;
        run_gt_q <= run_gt_d;
    end

    // Next-state logic, the byte-pair cascade step and the state-decoded outputs
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        run_eq_d     = run_eq_q;
        run_gt_d     = run_gt_q;
        eq_d         = eq_q;
        gt_d         = gt_q;
        done_d       = 1'b0;
        byte_ready_o = 1'b0;
        busy_o       = (state_q != IDLE);

        // A higher byte that has already decided the result masks every lower byte.
        pair_eq = run_eq_q & (a_byte_i == b_byte_i);
        pair_gt = run_gt_q | (run_eq_q & (a_byte_i > b_byte_i));

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = RUN;
                    count_d  = '0;
                    run_eq_d = 1'b1;
                    run_gt_d = 1'b0;
                end
            end
            RUN: begin
                byte_ready_o = 1'b1;
                if (byte_valid_i) begin
                    run_eq_d = pair_eq;
                    run_gt_d = pair_gt;
                    if (count_q == LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        eq_d    = pair_eq;
                        gt_d    = pair_gt;
                    end else begin
                        count_d = count_q + CW'(1);
`ifdef SMC_EARLY_DONE_EN
                        if (!pair_eq) begin
                            state_d = DRAIN;
                            done_d  = 1'b1;
                            eq_d    = pair_eq;
                            gt_d    = pair_gt;
                        end
`endif
                    end
                end
            end
`ifdef SMC_EARLY_DONE_EN
            DRAIN: begin
                byte_ready_o = 1'b1;
                if (byte_valid_i) begin
                    if (count_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done_o = done_q;
    assign eq_o   = eq_q;
    assign gt_o   = gt_q;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Directed testbench for serial_mag_compare.
// It uses a WORDS=4 instance and a WORDS=1 instance. The expected done
// timing follows the SMC_EARLY_DONE_EN build setting.
module tb_serial_mag_compare;

`ifdef SMC_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a_byte, b_byte;
    logic       byte_valid;
    logic       byte_ready, busy, done, eq, gt;

    logic       w1_start;
    logic [7:0] w1_a, w1_b;
    logic       w1_valid;
    logic       w1_ready, w1_busy, w1_done, w1_eq, w1_gt;

    int tests = 0;
    int fails = 0;

    // observations gathered by drive4
    int   cyc, ndone, dcyc, nacc;
    logic deq, dgt, rdy1;

    always #5 clk = ~clk;

    serial_mag_compare #(.WORDS(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .a_byte_i(a_byte), .b_byte_i(b_byte), .byte_valid_i(byte_valid),
        .byte_ready_o(byte_ready), .busy_o(busy), .done_o(done),
        .eq_o(eq), .gt_o(gt)
    );

    serial_mag_compare #(.WORDS(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(w1_start),
        .a_byte_i(w1_a), .b_byte_i(w1_b), .byte_valid_i(w1_valid),
        .byte_ready_o(w1_ready), .busy_o(w1_busy), .done_o(w1_done),
        .eq_o(w1_eq), .gt_o(w1_gt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock step for the WORDS=4 instance. It also counts handshakes and records the first done pulse.
    task automatic tick4();
        if (byte_valid && byte_ready) nacc++;
        tick();
        cyc++;
        if (done) begin
            ndone++;
            if (ndone == 1) begin
                dcyc = cyc;
                deq  = eq;
                dgt  = gt;
            end
        end
    endtask

    // Run one full comparison with bub idle cycles before each byte. Start may also be pulsed during those bubbles.
    task automatic drive4(input logic [31:0] a, input logic [31:0] b,
                          input int bub, input bit poke);
        cyc = 0; ndone = 0; nacc = 0; dcyc = -1; deq = 1'bx; dgt = 1'bx;
        start = 1'b1;
        tick4();
        start = 1'b0;
        rdy1 = byte_ready;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < bub; j++) begin
                byte_valid = 1'b0;
                start = poke;
                tick4();
                start = 1'b0;
            end
            byte_valid = 1'b1;
            a_byte = a[31-8*i -: 8];
            b_byte = b[31-8*i -: 8];
            tick4();
        end
        byte_valid = 1'b0;
        a_byte = 8'h00;
        b_byte = 8'h00;
        for (int k = 0; k < 4; k++) tick4();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; a_byte = 8'h00; b_byte = 8'h00;
        w1_start = 1'b0; w1_valid = 1'b0; w1_a = 8'h00; w1_b = 8'h00;
        tick(); tick();
        tests++; if ({byte_ready, busy, done, eq, gt} !== 5'b00000) begin
            fails++; $display("FAIL reset_outputs got %b exp 00000", {byte_ready, busy, done, eq, gt});
        end
        tests++; if ({w1_ready, w1_busy, w1_done, w1_eq, w1_gt} !== 5'b00000) begin
            fails++; $display("FAIL reset_outputs_w1 got %b exp 00000", {w1_ready, w1_busy, w1_done, w1_eq, w1_gt});
        end
        rst_n = 1'b1;
        tick();
        tests++; if ({byte_ready, busy} !== 2'b00) begin
            fails++; $display("FAIL idle_after_reset got %b exp 00", {byte_ready, busy});
        end
    endtask

    task automatic test_equal();
        drive4(32'h12345678, 32'h12345678, 0, 1'b0);
        tests++; if (rdy1 !== 1'b1) begin
            fails++; $display("FAIL eq_ready_t1 got %b exp 1", rdy1);
        end
        tests++; if (dcyc !== 5) begin
            fails++; $display("FAIL eq_done_cycle got %0d exp 5", dcyc);
        end
        tests++; if ({deq, dgt} !== 2'b10) begin
            fails++; $display("FAIL eq_flags got %b exp 10", {deq, dgt});
        end
        tests++; if (ndone !== 1 || nacc !== 4) begin
            fails++; $display("FAIL eq_counts got done=%0d acc=%0d exp done=1 acc=4", ndone, nacc);
        end
        tests++; if ({byte_ready, busy, eq, gt} !== 4'b0010) begin
            fails++; $display("FAIL eq_idle_hold got %b exp 0010", {byte_ready, busy, eq, gt});
        end
    endtask

    task automatic test_greater_less();
        drive4(32'h80000000, 32'h7FFFFFFF, 0, 1'b0);
        tests++; if ({deq, dgt} !== 2'b01) begin
            fails++; $display("FAIL gt_flags got %b exp 01", {deq, dgt});
        end
        tests++; if (dcyc !== (EARLY ? 2 : 5) || ndone !== 1 || nacc !== 4) begin
            fails++; $display("FAIL gt_timing got cyc=%0d done=%0d acc=%0d exp cyc=%0d done=1 acc=4",
                              dcyc, ndone, nacc, EARLY ? 2 : 5);
        end
        drive4(32'h12345677, 32'h12345678, 0, 1'b0);
        tests++; if ({deq, dgt} !== 2'b00 || dcyc !== 5) begin
            fails++; $display("FAIL lt_flags got eqgt=%b cyc=%0d exp eqgt=00 cyc=5", {deq, dgt}, dcyc);
        end
        tests++; if ({eq, gt, busy} !== 3'b000) begin
            fails++; $display("FAIL lt_hold got %b exp 000", {eq, gt, busy});
        end
    endtask

    task automatic test_early_done();
        drive4(32'h01000000, 32'h00FFFFFF, 0, 1'b0);
        tests++; if (dcyc !== (EARLY ? 2 : 5)) begin
            fails++; $display("FAIL early_done_cycle got %0d exp %0d", dcyc, EARLY ? 2 : 5);
        end
        tests++; if ({deq, dgt} !== 2'b01 || ndone !== 1 || nacc !== 4) begin
            fails++; $display("FAIL early_result got eqgt=%b done=%0d acc=%0d exp eqgt=01 done=1 acc=4",
                              {deq, dgt}, ndone, nacc);
        end
        tests++; if ({byte_ready, busy, gt} !== 3'b001) begin
            fails++; $display("FAIL early_idle got %b exp 001", {byte_ready, busy, gt});
        end
    endtask

    task automatic test_bubbles();
        drive4(32'hAABBCCDD, 32'hAABBCCDD, 2, 1'b1);
        tests++; if (dcyc !== 13 || ndone !== 1 || nacc !== 4) begin
            fails++; $display("FAIL bubble_timing got cyc=%0d done=%0d acc=%0d exp cyc=13 done=1 acc=4",
                              dcyc, ndone, nacc);
        end
        tests++; if ({deq, dgt} !== 2'b10) begin
            fails++; $display("FAIL bubble_flags got %b exp 10", {deq, dgt});
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen_done;
        start = 1'b1; tick(); start = 1'b0;
        byte_valid = 1'b1; a_byte = 8'h12; b_byte = 8'h12; tick();
        a_byte = 8'h34; b_byte = 8'h34; tick();
        a_byte = 8'h56; b_byte = 8'h56;
        rst_n = 1'b0; tick();
        tests++; if ({byte_ready, busy, done, eq, gt} !== 5'b00000) begin
            fails++; $display("FAIL midrun_reset got %b exp 00000", {byte_ready, busy, done, eq, gt});
        end
        rst_n = 1'b1; byte_valid = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        tests++; if (seen_done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL midrun_no_done got done=%b busy=%b exp done=0 busy=0", seen_done, busy);
        end
        drive4(32'h00000001, 32'h00000000, 0, 1'b0);
        tests++; if ({deq, dgt} !== 2'b01 || dcyc !== 5) begin
            fails++; $display("FAIL fresh_gt got eqgt=%b cyc=%0d exp eqgt=01 cyc=5", {deq, dgt}, dcyc);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; tick(); start = 1'b0;
        byte_valid = 1'b1; a_byte = 8'h5A; b_byte = 8'h5A;
        for (int i = 0; i < 4; i++) tick();
        byte_valid = 1'b0;
        tests++; if ({done, eq, gt} !== 3'b110) begin
            fails++; $display("FAIL b2b_first got %b exp 110", {done, eq, gt});
        end
        start = 1'b1;
        tick();
        tests++; if ({busy, done} !== 2'b00) begin
            fails++; $display("FAIL b2b_start_in_done got busy=%b done=%b exp 0 0", busy, done);
        end
        tick();
        start = 1'b0;
        tests++; if ({busy, byte_ready} !== 2'b11) begin
            fails++; $display("FAIL b2b_restart got %b exp 11", {busy, byte_ready});
        end
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_byte = (i == 3) ? 8'h02 : 8'h00;
            b_byte = (i == 3) ? 8'h03 : 8'h00;
            tick();
        end
        byte_valid = 1'b0;
        tests++; if ({done, eq, gt} !== 3'b100) begin
            fails++; $display("FAIL b2b_second got %b exp 100", {done, eq, gt});
        end
        tick();
    endtask

    task automatic test_single_word();
        w1_start = 1'b1; tick(); w1_start = 1'b0;
        tests++; if (w1_ready !== 1'b1) begin
            fails++; $display("FAIL w1_ready got %b exp 1", w1_ready);
        end
        w1_valid = 1'b1; w1_a = 8'h05; w1_b = 8'h09; tick();
        w1_valid = 1'b0;
        tests++; if ({w1_done, w1_eq, w1_gt} !== 3'b100) begin
            fails++; $display("FAIL w1_lt got %b exp 100", {w1_done, w1_eq, w1_gt});
        end
        tick();
        w1_start = 1'b1; tick(); w1_start = 1'b0;
        w1_valid = 1'b1; w1_a = 8'hC3; w1_b = 8'h3C; tick();
        w1_valid = 1'b0;
        tests++; if ({w1_done, w1_eq, w1_gt} !== 3'b101) begin
            fails++; $display("FAIL w1_gt got %b exp 101", {w1_done, w1_eq, w1_gt});
        end
        tick();
        tests++; if ({w1_done, w1_busy, w1_ready, w1_gt} !== 4'b0001) begin
            fails++; $display("FAIL w1_idle got %b exp 0001", {w1_done, w1_busy, w1_ready, w1_gt});
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_greater_less();
        test_early_done();
        test_bubbles();
        test_reset_mid_run();
        test_back_to_back();
        test_single_word();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
